// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, n-cycle latency.
// Define DIV_SIGNED_EN for two's complement operands (truncating quotient, remainder signed like a).
module seq_divider #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic [n-1:0] quo,
   output logic [n-1:0] rem,
   output logic         busy,
   output logic         done,
   output logic         div_zero
);

   localparam int CW = (n > 2) ? $clog2(n) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ZERO
   } state_t;

   state_t state;
   state_t next_state;

   logic [CW-1:0] count;
   logic [n-1:0]  work_r;
   logic [n-1:0]  work_q;
   logic [n-1:0]  divisor;

   logic [n:0]    shifted;
   logic [n:0]    trial;
   logic          q_bit;
   logic [n-1:0]  next_r;
   logic [n-1:0]  next_q;
   logic [n-1:0]  final_q;
   logic [n-1:0]  final_r;
   logic [n-1:0]  mag_a;
   logic [n-1:0]  mag_b;
   logic          last_iter;
   logic          accept;

   assign busy      = (state != IDLE);
   assign accept    = (state == IDLE) && start;
   assign last_iter = (count == CW'(n - 1));

   // The stored remainder is always below the divisor, so n bits suffice;
   // the shifted remainder and trial difference carry the extra sign bit.
   assign shifted = {work_r, work_q[n-1]};
   assign trial   = shifted - {1'b0, divisor};
   assign q_bit   = ~trial[n];
   assign next_r  = q_bit ? trial[n-1:0] : shifted[n-1:0];
   assign next_q  = {work_q[n-2:0], q_bit};

`ifdef DIV_SIGNED_EN
   logic neg_q;
   logic neg_r;

   assign mag_a   = a[n-1] ? -a : a;
   assign mag_b   = b[n-1] ? -b : b;
   assign final_q = neg_q ? -next_q : next_q;
   assign final_r = neg_r ? -next_r : next_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= a[n-1] ^ b[n-1];
         neg_r <= a[n-1];
      end
   end
`else
   assign mag_a   = a;
   assign mag_b   = b;
   assign final_q = next_q;
   assign final_r = next_r;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (b == '0) ? ZERO : RUN;
            end
         end
         RUN: begin
            if (last_iter) begin
               next_state = IDLE;
            end
         end
         ZERO:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Visible results change only on the completing edge; work registers carry the iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         work_r   <= '0;
         work_q   <= '0;
         divisor  <= '0;
         quo      <= '0;
         rem      <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  div_zero <= 1'b0;
                  count    <= '0;
                  work_r   <= '0;
                  work_q   <= (b == '0) ? a : mag_a;
                  divisor  <= mag_b;
               end
            end
            RUN: begin
               work_r <= next_r;
               work_q <= next_q;
               count  <= count + 1'b1;
               if (last_iter) begin
                  quo  <= final_q;
                  rem  <= final_r;
                  done <= 1'b1;
               end
            end
            ZERO: begin
               quo      <= '1;
               rem      <= work_q;
               div_zero <= 1'b1;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter n, default 8, the operand and result width in bits (n >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled on the clk edge.
REQ-005 SHALL have port a, input, n, dividend; sampled only on an accepted start.
REQ-006 SHALL have port b, input, n, divisor; sampled only on an accepted start.
REQ-007 SHALL have port quo, output, n, quotient, registered.
REQ-008 SHALL have port rem, output, n, remainder, registered.
REQ-009 SHALL have port busy, output, 1, high while a division is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking quo/rem valid.
REQ-011 SHALL have port div_zero, output, 1, high with done when the divisor was zero; held until the next accepted start.

Function
REQ-012 SHALL implement restoring division, one quotient bit per cycle, MSB first, by trial subtraction of the divisor from the partial remainder.
- Width rule: the partial remainder and the trial difference are n+1 bits.
- The trial difference's sign bit selects restore (keep the old remainder, q bit 0) or keep (take the difference, q bit 1).
REQ-013 SHALL use three states.
- IDLE -> RUN on accepted start with b != 0.
- IDLE -> ZERO on accepted start with b == 0.
- RUN -> IDLE after the n-th iteration.
- ZERO -> IDLE after one cycle.
REQ-014 SHALL accept start only when busy = 0; start while busy = 1 SHALL be ignored with no effect on operands or outputs.
REQ-015 SHALL set busy = 1 from the edge accepting start until the edge completing the operation.
REQ-016 SHALL have latency n cycles for b != 0.
- Start accepted at edge E0; iterations occur at edges E1..En.
- After En: done = 1 for exactly one cycle, busy = 0, and quo/rem hold the final values.
REQ-017 SHALL handle divide by zero with a latency of 1 cycle: after E1, done = 1, div_zero = 1, quo = all ones, rem = a.
REQ-018 SHALL hold quo, rem and div_zero stable from done until the next accepted start; they SHALL not change during RUN.
REQ-019 SHALL accept a start asserted in the same cycle as done (busy = 0 in that cycle), giving back-to-back operation.
REQ-020 SHALL clear div_zero on any accepted start.
REQ-021 SHALL in unsigned mode produce quo = floor(a/b) and rem = a - quo*b, for example a = 255, b = 255 gives 1, 0 and a < b gives 0, a.

Reset
REQ-022 SHALL, when rst = 1 at a clk edge, force IDLE, quo = 0, rem = 0, busy = 0, done = 0 and div_zero = 0.
REQ-023 SHALL, on reset asserted during RUN or ZERO, abort the operation with no done pulse; start SHALL be ignored while rst = 1.

Configuration
REQ-024 SHALL honour macro DIV_SIGNED_EN.
- Defined: a and b are two's complement values. Operand magnitudes are taken at capture and the signs are applied on the final iteration edge, so latency is unchanged.
- Defined, sign rules: the quotient truncates toward zero and rem takes the sign of a.
- Defined, overflow: most-negative / -1 gives quo = most-negative and rem = 0.
- Defined, divide by zero: quo = all ones and rem = a.
- Undefined: unsigned only, and no sign logic is synthesized.

Verification
REQ-025 SHALL cover: a = 100, b = 7, start pulse -> done exactly 8 cycles after acceptance, quo = 14, rem = 2, div_zero = 0.
REQ-026 SHALL cover: a = 5, b = 0 -> done 1 cycle after acceptance, div_zero = 1, quo = 8'hFF, rem = 8'h05.
REQ-027 SHALL cover: a = 200, b = 3 accepted, then a = 9, b = 9 with start at cycle 3 -> second start ignored, result quo = 66, rem = 2.
REQ-028 SHALL cover: start a = 255, b = 1 with the next start asserted in the done cycle using a = 10, b = 4 -> quo = 255, rem = 0, then quo = 2, rem = 2 with no idle gap.
REQ-029 SHALL cover: rst asserted 4 cycles into a division -> no done pulse, and all outputs 0 on the following cycle.
REQ-030 SHALL cover, with DIV_SIGNED_EN defined: a = 8'hF9 (-7), b = 2 -> quo = 8'hFD (-3), rem = 8'hFF (-1); and a = 8'h80, b = 8'hFF -> quo = 8'h80, rem = 0.
